datapath_unit: RTL and testbench
================================

// Module: datapath_unit
// PURPOSE
// - 32-bit single-bus CPU datapath: 16 GPRs, HI, LO, PC, IR, MAR, MDR, INPORT, Y and a 64-bit Z result register.
// - Sources drive a shared bus through an encoder and mux; sinks load from the bus on the clock edge.
// - ALU supports AND, PC increment and ADD. The control unit sits above this block and drives all in/out strobes.
// PARAMETERS
// - W  32  datapath width (fixed; Z is 2*W)
// PORTS
// - Clock  in  1  rising-edge clock for all registers
// - Clear  in  1  asynchronous active-high reset
// - R0in..R15in,HIin,LOin,PCin,MDRin,INPORTin,Zin,Yin,MARin,IRin  in  1 each  register load enables
// - AND  in  1  ALU select: Z = Y & bus
// - IncPC  in  1  ALU select: Z = bus + 1 (overrides AND)
// - R0out..R15out,HIout,LOout,ZHIout,ZLOout,PCout,MDRout,INPORTout,Zout,Yout  in  1 each  bus source selects
// - Read  in  1  MDR input select: 1=Mdatain, 0=bus
// - Mdatain  in  32  memory read data
// - busMuxOut  out  32  shared bus value
// - encoderOut  out  5  encoded bus source code
// - BusMuxInR0..R15,HI,LO,Zhi,Zlo,PC,MDR,Inport,Y  out  32 each  register contents (bus mux inputs, observable)
// BEHAVIOUR
// - Clear asserted: every register (R0-R15, HI, LO, PC, IR, MAR, MDR, INPORT, Y, Z) goes to 0 immediately;
//   with no out-select asserted, busMuxOut=0 and encoderOut=31.
// - Encoder codes: R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19 (Zout aliases ZLOout), PC=20,
//   MDR=21, INPORT=22, Y=23.
// - Encoder priority: lowest code wins when several selects are high. No select asserted -> code 31.
// - Bus mux is combinational. Codes 24-31 drive 0.
// - Register load: on rising Clock with Xin=1, X <= busMuxOut. Zero-cycle latency to the bus, one edge to load.
// - MDR: on rising Clock with MDRin=1, MDR <= (Read ? Mdatain : busMuxOut).
// - INPORT: loads from bus on INPORTin (external port not modelled). IR and MAR load from bus and have no bus output.
// - ALU is combinational and loads Z on Zin:
//   - IncPC=1: Z = {32'b0, bus+1}, wrapping 0xFFFFFFFF -> 0.
//   - else AND=1: Z = {32'b0, Y & bus}.
//   - else: Z = {32'b0 or carry, Y + bus}, with the carry in ZHI bit 0.
// - Same register as source and sink in one cycle: the old value is driven and the new value is loaded at the edge.
// - Clear mid-operation: clears immediately, overriding all load enables; loads resume on the first edge after Clear falls.
// TESTING
// - Assert Clear -> all BusMuxIn* = 0, busMuxOut = 0, encoderOut = 31.
// - Mdatain=0x00000012, Read=MDRin=1 for one edge, then MDRout=R1in=1 -> BusMuxInMDR=0x12, encoderOut=21, BusMuxInR1=0x12.
// - PC=0: PCout=MARin=IncPC=Zin=1 -> Zlo=1. Then ZLOout=PCin=1 -> PC=1, encoderOut=19.
// - Mdatain=0x88918000, Read=MDRin=1, then MDRout=IRin=1 -> IR=0x88918000.
// - R2=0xF0F0F0F0, R3=0xFF00FF00: R2out=Yin=1; R3out=AND=Zin=1; ZLOout=R0in=1 -> R0=0xF000F000, Zhi=0.
// - R4out and R9out both high -> encoderOut=4, bus=R4. Default ADD 0xFFFFFFFF+1 -> Zlo=0, Zhi=1.

Source files
------------

// File: rtl/datapath_unit.sv
// datapath_unit: single-bus 32-bit CPU datapath with 24-source priority-encoded bus, GPRs, special registers and ALU.
// Sinks load from the bus on the rising Clock edge; Clear resets every register asynchronously.
module datapath_unit #(
   parameter int W = 32
) (
   input  logic         Clock,
   input  logic         Clear,
   input  logic         R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
   input  logic         R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic         HIin, LOin, PCin, MDRin, INPORTin, Zin, Yin, MARin, IRin,
   input  logic         AND,
   input  logic         IncPC,
   input  logic         R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic         R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic         HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Zout, Yout,
   input  logic         Read,
   input  logic [W-1:0] Mdatain,
   output logic [W-1:0] busMuxOut,
   output logic [4:0]   encoderOut,
   output logic [W-1:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
   output logic [W-1:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
   output logic [W-1:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
   output logic [W-1:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
   output logic [W-1:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo,
   output logic [W-1:0] BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInY,
   output logic [W-1:0] IRdata,
   output logic [W-1:0] MARdata
);
   logic [W-1:0]   r_gpr [16];
   logic [W-1:0]   r_hi, r_lo, r_pc, r_ir, r_mar, r_mdr, r_inport, r_y;
   logic [2*W-1:0] r_z;
   logic [15:0]    w_rin, w_rout;
   logic [23:0]    w_sel;
   logic [2*W-1:0] w_alu;

   assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
   // bit index equals the encoder code; Zout is an alias for the low half of Z
   assign w_sel  = {Yout, INPORTout, MDRout, PCout, ZLOout | Zout, ZHIout, LOout, HIout, w_rout};

   always_comb begin
      encoderOut = 5'd31;
      for (int i = 23; i >= 0; i--)
         if (w_sel[i]) encoderOut = 5'(i);
   end

   always_comb begin
      case (encoderOut)
         5'd16:   busMuxOut = r_hi;
         5'd17:   busMuxOut = r_lo;
         5'd18:   busMuxOut = r_z[2*W-1:W];
         5'd19:   busMuxOut = r_z[W-1:0];
         5'd20:   busMuxOut = r_pc;
         5'd21:   busMuxOut = r_mdr;
         5'd22:   busMuxOut = r_inport;
         5'd23:   busMuxOut = r_y;
         default: busMuxOut = encoderOut[4] ? '0 : r_gpr[encoderOut[3:0]];
      endcase
   end

   // the default ADD places the carry-out in bit 0 of the high half
   assign w_alu = IncPC ? {{W{1'b0}}, busMuxOut + W'(1)} :
                  AND   ? {{W{1'b0}}, r_y & busMuxOut} :
                          {{(W-1){1'b0}}, {1'b0, r_y} + {1'b0, busMuxOut}};

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_pc     <= '0;
         r_ir     <= '0;
         r_mar    <= '0;
         r_mdr    <= '0;
         r_inport <= '0;
         r_y      <= '0;
         r_z      <= '0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (w_rin[i]) r_gpr[i] <= busMuxOut;
         if (HIin)     r_hi     <= busMuxOut;
         if (LOin)     r_lo     <= busMuxOut;
         if (PCin)     r_pc     <= busMuxOut;
         if (IRin)     r_ir     <= busMuxOut;
         if (MARin)    r_mar    <= busMuxOut;
         if (MDRin)    r_mdr    <= Read ? Mdatain : busMuxOut;
         if (INPORTin) r_inport <= busMuxOut;
         if (Yin)      r_y      <= busMuxOut;
         if (Zin)      r_z      <= w_alu;
      end
   end

   assign BusMuxInR0     = r_gpr[0];
   assign BusMuxInR1     = r_gpr[1];
   assign BusMuxInR2     = r_gpr[2];
   assign BusMuxInR3     = r_gpr[3];
   assign BusMuxInR4     = r_gpr[4];
   assign BusMuxInR5     = r_gpr[5];
   assign BusMuxInR6     = r_gpr[6];
   assign BusMuxInR7     = r_gpr[7];
   assign BusMuxInR8     = r_gpr[8];
   assign BusMuxInR9     = r_gpr[9];
   assign BusMuxInR10    = r_gpr[10];
   assign BusMuxInR11    = r_gpr[11];
   assign BusMuxInR12    = r_gpr[12];
   assign BusMuxInR13    = r_gpr[13];
   assign BusMuxInR14    = r_gpr[14];
   assign BusMuxInR15    = r_gpr[15];
   assign BusMuxInHI     = r_hi;
   assign BusMuxInLO     = r_lo;
   assign BusMuxInZhi    = r_z[2*W-1:W];
   assign BusMuxInZlo    = r_z[W-1:0];
   assign BusMuxInPC     = r_pc;
   assign BusMuxInMDR    = r_mdr;
   assign BusMuxInInport = r_inport;
   assign BusMuxInY      = r_y;
   assign IRdata         = r_ir;
   assign MARdata        = r_mar;
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: directed sequences, a selector table and random traffic checked against a register-file model.
module tb_datapath_unit;
   logic        Clock = 1'b0;
   logic        Clear = 1'b0;
   logic [15:0] rin;
   logic        hiin, loin, pcin, mdrin, inin, zin, yin, marin, irin, and_s, inc, rd, zout;
   logic [23:0] so;
   logic [31:0] mdat;
   logic [31:0] bus;
   logic [4:0]  enc;
   logic [31:0] bm [24];
   logic [31:0] ir, mar;
   logic [31:0] m [24];
   logic [31:0] m_ir, m_mar;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [23:0] sel;
      logic        z;
      logic [4:0]  code;
   } vec_t;
   vec_t tv [14];

   always #5 Clock = ~Clock;

   datapath_unit dut (
      .Clock(Clock), .Clear(Clear),
      .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
      .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
      .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
      .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
      .HIin(hiin), .LOin(loin), .PCin(pcin), .MDRin(mdrin), .INPORTin(inin),
      .Zin(zin), .Yin(yin), .MARin(marin), .IRin(irin),
      .AND(and_s), .IncPC(inc),
      .R0out(so[0]), .R1out(so[1]), .R2out(so[2]), .R3out(so[3]),
      .R4out(so[4]), .R5out(so[5]), .R6out(so[6]), .R7out(so[7]),
      .R8out(so[8]), .R9out(so[9]), .R10out(so[10]), .R11out(so[11]),
      .R12out(so[12]), .R13out(so[13]), .R14out(so[14]), .R15out(so[15]),
      .HIout(so[16]), .LOout(so[17]), .ZHIout(so[18]), .ZLOout(so[19]),
      .PCout(so[20]), .MDRout(so[21]), .INPORTout(so[22]), .Zout(zout), .Yout(so[23]),
      .Read(rd), .Mdatain(mdat),
      .busMuxOut(bus), .encoderOut(enc),
      .BusMuxInR0(bm[0]), .BusMuxInR1(bm[1]), .BusMuxInR2(bm[2]), .BusMuxInR3(bm[3]),
      .BusMuxInR4(bm[4]), .BusMuxInR5(bm[5]), .BusMuxInR6(bm[6]), .BusMuxInR7(bm[7]),
      .BusMuxInR8(bm[8]), .BusMuxInR9(bm[9]), .BusMuxInR10(bm[10]), .BusMuxInR11(bm[11]),
      .BusMuxInR12(bm[12]), .BusMuxInR13(bm[13]), .BusMuxInR14(bm[14]), .BusMuxInR15(bm[15]),
      .BusMuxInHI(bm[16]), .BusMuxInLO(bm[17]), .BusMuxInZhi(bm[18]), .BusMuxInZlo(bm[19]),
      .BusMuxInPC(bm[20]), .BusMuxInMDR(bm[21]), .BusMuxInInport(bm[22]), .BusMuxInY(bm[23]),
      .IRdata(ir), .MARdata(mar)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      rin = '0; so = '0; zout = 0; mdat = '0;
      {hiin, loin, pcin, mdrin, inin, zin, yin, marin, irin, and_s, inc, rd} = '0;
   endtask

   function automatic logic [4:0] exp_code();
      for (int i = 0; i < 24; i++)
         if (so[i] || (i == 19 && zout)) return 5'(i);
      return 5'd31;
   endfunction

   function automatic logic [31:0] exp_bus(input logic [4:0] c);
      return (c < 24) ? m[c] : 32'h0;
   endfunction

   task automatic check_all();
      for (int i = 0; i < 24; i++) chk($sformatf("reg%0d", i), bm[i], m[i]);
      chk("ir", ir, m_ir);
      chk("mar", mar, m_mar);
   endtask

   task automatic cyc();
      logic [4:0]  c;
      logic [31:0] b;
      logic [63:0] z;
      logic [31:0] nm [24];
      #1;
      c = exp_code();
      b = exp_bus(c);
      chk("enc", enc, c);
      chk("bus", bus, b);
      z = inc ? {32'h0, b + 32'd1} : and_s ? {32'h0, m[23] & b} : {32'h0, m[23]} + {32'h0, b};
      nm = m;
      for (int i = 0; i < 16; i++) if (rin[i]) nm[i] = b;
      if (hiin)  nm[16] = b;
      if (loin)  nm[17] = b;
      if (zin)   {nm[18], nm[19]} = z;
      if (pcin)  nm[20] = b;
      if (mdrin) nm[21] = rd ? mdat : b;
      if (inin)  nm[22] = b;
      if (yin)   nm[23] = b;
      @(posedge Clock);
      #1;
      m = nm;
      if (irin)  m_ir = b;
      if (marin) m_mar = b;
      check_all();
      idle();
   endtask

   // load enables held high with live data during Clear must have no effect
   task automatic do_clear();
      idle();
      rin = '1;
      {hiin, loin, pcin, mdrin, inin, zin, yin, marin, irin, rd} = '1;
      mdat = $urandom | 32'h1;
      Clear = 1;
      #1;
      for (int i = 0; i < 24; i++) m[i] = '0;
      m_ir = '0; m_mar = '0;
      check_all();
      chk("clr_enc", enc, 31);
      chk("clr_bus", bus, 0);
      @(posedge Clock);
      #1;
      check_all();
      Clear = 0;
      idle();
   endtask

   task automatic rand_inputs();
      idle();
      case ($urandom_range(0, 3))
         0: so = '0;
         1: so[$urandom_range(0, 23)] = 1'b1;
         2: begin so[$urandom_range(0, 23)] = 1'b1; so[$urandom_range(0, 23)] = 1'b1; end
         default: so = 24'($urandom & $urandom);
      endcase
      zout  = ($urandom_range(0, 7) == 0);
      rin   = 16'($urandom & $urandom & $urandom);
      hiin  = ($urandom_range(0, 3) == 0);
      loin  = ($urandom_range(0, 3) == 0);
      pcin  = ($urandom_range(0, 3) == 0);
      mdrin = ($urandom_range(0, 2) == 0);
      inin  = ($urandom_range(0, 3) == 0);
      zin   = ($urandom_range(0, 2) == 0);
      yin   = ($urandom_range(0, 2) == 0);
      marin = ($urandom_range(0, 3) == 0);
      irin  = ($urandom_range(0, 3) == 0);
      and_s = ($urandom_range(0, 2) == 0);
      inc   = ($urandom_range(0, 3) == 0);
      rd    = ($urandom_range(0, 1) == 0);
      mdat  = $urandom;
   endtask

   task automatic load_gpr(input int r, input logic [31:0] v);
      mdat = v; rd = 1; mdrin = 1;
      cyc();
      so[21] = 1; rin[r] = 1;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tv[0]  = '{24'h000000, 1'b0, 5'd31};
      tv[1]  = '{24'h000000, 1'b1, 5'd19};
      tv[2]  = '{24'h000201, 1'b0, 5'd0};
      tv[3]  = '{24'h800000, 1'b0, 5'd23};
      tv[4]  = '{24'h0C0000, 1'b0, 5'd18};
      tv[5]  = '{24'h080000, 1'b0, 5'd19};
      tv[6]  = '{24'h100000, 1'b0, 5'd20};
      tv[7]  = '{24'h600000, 1'b0, 5'd21};
      tv[8]  = '{24'h010010, 1'b0, 5'd4};
      tv[9]  = '{24'h030000, 1'b0, 5'd16};
      tv[10] = '{24'h020000, 1'b0, 5'd17};
      tv[11] = '{24'h400000, 1'b0, 5'd22};
      tv[12] = '{24'h000200, 1'b1, 5'd9};
      tv[13] = '{24'h00FFFE, 1'b0, 5'd1};
      idle();
      do_clear();

      mdat = 32'h00000012; rd = 1; mdrin = 1;
      cyc();
      chk("mdr_load", bm[21], 32'h12);
      so[21] = 1; rin[1] = 1;
      #1 chk("enc_mdr", enc, 21);
      cyc();
      chk("r1_load", bm[1], 32'h12);

      so[20] = 1; marin = 1; inc = 1; zin = 1;
      cyc();
      chk("zlo_inc", bm[19], 1);
      chk("mar_pc", mar, 0);
      so[19] = 1; pcin = 1;
      #1 chk("enc_zlo", enc, 19);
      cyc();
      chk("pc_inc", bm[20], 1);

      mdat = 32'h88918000; rd = 1; mdrin = 1;
      cyc();
      so[21] = 1; irin = 1;
      cyc();
      chk("ir_load", ir, 32'h88918000);

      load_gpr(2, 32'hF0F0F0F0);
      load_gpr(3, 32'hFF00FF00);
      so[2] = 1; yin = 1;
      cyc();
      so[3] = 1; and_s = 1; zin = 1;
      cyc();
      so[19] = 1; rin[0] = 1;
      cyc();
      chk("and_r0", bm[0], 32'hF000F000);
      chk("and_zhi", bm[18], 0);

      load_gpr(4, 32'hFFFFFFFF);
      load_gpr(9, 32'h00000007);
      load_gpr(5, 32'h00000001);
      so[4] = 1; so[9] = 1; yin = 1;
      #1 chk("prio_enc", enc, 4);
      chk("prio_bus", bus, 32'hFFFFFFFF);
      cyc();
      so[5] = 1; zin = 1;
      cyc();
      chk("add_zlo", bm[19], 0);
      chk("add_zhi", bm[18], 1);

      so[19] = 1; zin = 1; inc = 1;
      #1 chk("self_old", bus, 0);
      cyc();
      chk("self_new", bm[19], 1);

      for (int i = 0; i < 14; i++) begin
         so = tv[i].sel; zout = tv[i].z;
         #1;
         chk($sformatf("tv%0d_enc", i), enc, tv[i].code);
         chk($sformatf("tv%0d_bus", i), bus, exp_bus(tv[i].code));
      end
      idle();
      @(posedge Clock);
      #1;

      do_clear();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 49) == 0) do_clear();
         else begin
            rand_inputs();
            cyc();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
